// File: rtl/alu_pkg.sv
// Shared opcode, condition-code and flag-index definitions for the execute stage.
package alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned COND_W = 4;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'h0;
    localparam logic [OP_W-1:0] OP_EOR = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_RSB = 4'h3;
    localparam logic [OP_W-1:0] OP_ADD = 4'h4;
    localparam logic [OP_W-1:0] OP_ADC = 4'h5;
    localparam logic [OP_W-1:0] OP_SBC = 4'h6;
    localparam logic [OP_W-1:0] OP_RSC = 4'h7;
    localparam logic [OP_W-1:0] OP_TST = 4'h8;
    localparam logic [OP_W-1:0] OP_TEQ = 4'h9;
    localparam logic [OP_W-1:0] OP_CMP = 4'hA;
    localparam logic [OP_W-1:0] OP_CMN = 4'hB;
    localparam logic [OP_W-1:0] OP_ORR = 4'hC;
    localparam logic [OP_W-1:0] OP_MOV = 4'hD;
    localparam logic [OP_W-1:0] OP_BIC = 4'hE;
    localparam logic [OP_W-1:0] OP_MVN = 4'hF;

    localparam logic [COND_W-1:0] COND_EQ = 4'h0;
    localparam logic [COND_W-1:0] COND_NE = 4'h1;
    localparam logic [COND_W-1:0] COND_CS = 4'h2;
    localparam logic [COND_W-1:0] COND_CC = 4'h3;
    localparam logic [COND_W-1:0] COND_MI = 4'h4;
    localparam logic [COND_W-1:0] COND_PL = 4'h5;
    localparam logic [COND_W-1:0] COND_VS = 4'h6;
    localparam logic [COND_W-1:0] COND_VC = 4'h7;
    localparam logic [COND_W-1:0] COND_HI = 4'h8;
    localparam logic [COND_W-1:0] COND_LS = 4'h9;
    localparam logic [COND_W-1:0] COND_GE = 4'hA;
    localparam logic [COND_W-1:0] COND_LT = 4'hB;
    localparam logic [COND_W-1:0] COND_GT = 4'hC;
    localparam logic [COND_W-1:0] COND_LE = 4'hD;
    localparam logic [COND_W-1:0] COND_AL = 4'hE;
    localparam logic [COND_W-1:0] COND_NV = 4'hF;

    // Flag register layout is {N,Z,C,V}
    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;

    // TST/TEQ/CMP/CMN: always set flags, never write a register
    function automatic logic is_test_op(input logic [OP_W-1:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluation against the current NZCV flags.
module cond_check
    import alu_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              pass
);

    logic n, z, c, v;

    always_comb begin
        n    = flags[FLAG_N];
        z    = flags[FLAG_Z];
        c    = flags[FLAG_C];
        v    = flags[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_execute.sv
// Registered ARM data-processing execute stage with NZCV flag register and
// valid/ready output handshake.
module alu_execute
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [3:0]        cond,
    input  logic [3:0]        aluOp,
    input  logic              setFlags,
    input  logic [REG_W-1:0]  rdIndex,
    input  logic [DATA_W-1:0] rnData,
    input  logic [DATA_W-1:0] operand2,
    input  logic              shifterCarry,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] result,
    output logic [REG_W-1:0]  rdOut,
    output logic              writeEn,
    output logic [3:0]        flags
);

    logic              cond_pass_c;
    logic              accept_c;
    logic              is_test_c;
    logic              is_arith_c;
    logic              invert_c;
    logic              carry_in_c;
    logic [DATA_W-1:0] op_a_c;
    logic [DATA_W-1:0] op_b_c;
    logic [DATA_W-1:0] op_b_eff_c;
    logic [DATA_W:0]   sum_c;
    logic [DATA_W-1:0] alu_res_c;
    logic [3:0]        flags_next_c;

    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags),
        .pass  (cond_pass_c)
    );

    assign inReady   = !outValid || outReady;
    assign accept_c  = inValid && inReady;
    assign is_test_c = is_test_op(aluOp);

    // Operand steering: reverse ops swap A/B, subtracts invert B and pick carry-in
    always_comb begin
        op_a_c     = rnData;
        op_b_c     = operand2;
        invert_c   = 1'b0;
        carry_in_c = 1'b0;
        is_arith_c = 1'b0;
        case (aluOp)
            OP_SUB, OP_CMP: begin
                invert_c   = 1'b1;
                carry_in_c = 1'b1;
                is_arith_c = 1'b1;
            end
            OP_RSB: begin
                op_a_c     = operand2;
                op_b_c     = rnData;
                invert_c   = 1'b1;
                carry_in_c = 1'b1;
                is_arith_c = 1'b1;
            end
            OP_ADD, OP_CMN: is_arith_c = 1'b1;
            OP_ADC: begin
                carry_in_c = flags[FLAG_C];
                is_arith_c = 1'b1;
            end
            OP_SBC: begin
                invert_c   = 1'b1;
                carry_in_c = flags[FLAG_C];
                is_arith_c = 1'b1;
            end
            OP_RSC: begin
                op_a_c     = operand2;
                op_b_c     = rnData;
                invert_c   = 1'b1;
                carry_in_c = flags[FLAG_C];
                is_arith_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign op_b_eff_c = invert_c ? ~op_b_c : op_b_c;
    assign sum_c      = {1'b0, op_a_c} + {1'b0, op_b_eff_c} + (DATA_W+1)'(carry_in_c);

    always_comb begin
        alu_res_c = sum_c[DATA_W-1:0];
        case (aluOp)
            OP_AND, OP_TST: alu_res_c = rnData & operand2;
            OP_EOR, OP_TEQ: alu_res_c = rnData ^ operand2;
            OP_ORR:         alu_res_c = rnData | operand2;
            OP_MOV:         alu_res_c = operand2;
            OP_BIC:         alu_res_c = rnData & ~operand2;
            OP_MVN:         alu_res_c = ~operand2;
            default: ;
        endcase
    end

    // Logical ops take C from the shifter and keep V
    always_comb begin
        flags_next_c         = flags;
        flags_next_c[FLAG_N] = alu_res_c[DATA_W-1];
        flags_next_c[FLAG_Z] = (alu_res_c == '0);
        if (is_arith_c) begin
            flags_next_c[FLAG_C] = sum_c[DATA_W];
            flags_next_c[FLAG_V] = (op_a_c[DATA_W-1] == op_b_eff_c[DATA_W-1]) &&
                                   (alu_res_c[DATA_W-1] != op_a_c[DATA_W-1]);
        end else begin
            flags_next_c[FLAG_C] = shifterCarry;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outValid <= 1'b0;
            result   <= '0;
            rdOut    <= '0;
            writeEn  <= 1'b0;
        end else if (accept_c) begin
            outValid <= 1'b1;
            result   <= alu_res_c;
            rdOut    <= rdIndex;
            writeEn  <= cond_pass_c && !is_test_c;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flags <= 4'b0000;
        end else if (accept_c && cond_pass_c && (setFlags || is_test_c)) begin
            flags <= flags_next_c;
        end
    end

endmodule

// File: tb/tb_alu_execute.sv
// Scoreboard bench for alu_execute: reference model predicts result/flags per accepted op.
module tb_alu_execute;

    logic        clk = 1'b0;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [3:0]  cond;
    logic [3:0]  aluOp;
    logic        setFlags;
    logic [3:0]  rdIndex;
    logic [31:0] rnData;
    logic [31:0] operand2;
    logic        shifterCarry;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic [3:0]  rdOut;
    logic        writeEn;
    logic [3:0]  flags;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        we;
    } exp_t;

    exp_t        sb_q[$];
    logic [3:0]  m_flags;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        rand_rdy = 1'b0;

    alu_execute #(.DATA_W(32), .REG_W(4)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .inValid      (inValid),
        .inReady      (inReady),
        .cond         (cond),
        .aluOp        (aluOp),
        .setFlags     (setFlags),
        .rdIndex      (rdIndex),
        .rnData       (rnData),
        .operand2     (operand2),
        .shifterCarry (shifterCarry),
        .outValid     (outValid),
        .outReady     (outReady),
        .result       (result),
        .rdOut        (rdOut),
        .writeEn      (writeEn),
        .flags        (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flags are {N,Z,C,V}
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy & !z;
            4'd9:  return !cy | z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z & (n == v);
            4'd13: return z | (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: unsigned compare for carry/borrow, 64-bit signed range test for overflow
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic shc, input logic [3:0] f,
                            output logic [31:0] r, output logic [3:0] nf);
        longint sa, sb, sr;
        logic   cin, arith, cy, v;
        logic [32:0] wide;
        cin = f[1]; arith = 1'b1; cy = 1'b0; v = f[0];
        sa = longint'($signed(a)); sb = longint'($signed(b)); sr = 0;
        r = 32'd0;
        case (op)
            4'h0, 4'h8: begin r = a & b; arith = 1'b0; end
            4'h1, 4'h9: begin r = a ^ b; arith = 1'b0; end
            4'hC: begin r = a | b;  arith = 1'b0; end
            4'hD: begin r = b;      arith = 1'b0; end
            4'hE: begin r = a & ~b; arith = 1'b0; end
            4'hF: begin r = ~b;     arith = 1'b0; end
            4'h2, 4'hA: begin r = a - b; cy = (a >= b); sr = sa - sb; end
            4'h3: begin r = b - a; cy = (b >= a); sr = sb - sa; end
            4'h4, 4'hB: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; cy = wide[32]; sr = sa + sb; end
            4'h5: begin wide = {1'b0, a} + {1'b0, b} + {32'd0, cin}; r = wide[31:0]; cy = wide[32];
                        sr = sa + sb + longint'(cin); end
            4'h6: begin r = a - b - {31'd0, !cin}; cy = ({1'b0, a} >= ({1'b0, b} + {32'd0, !cin}));
                        sr = sa - sb - longint'(!cin); end
            default: begin r = b - a - {31'd0, !cin}; cy = ({1'b0, b} >= ({1'b0, a} + {32'd0, !cin}));
                        sr = sb - sa - longint'(!cin); end
        endcase
        if (arith) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        else       cy = shc;
        nf = {r[31], (r == 32'd0), cy, v};
    endtask

    task automatic issue(input logic [3:0] c, input logic [3:0] op, input logic s, input logic [3:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic shc);
        logic        accepted;
        logic        pass, test;
        logic [31:0] r;
        logic [3:0]  nf;
        exp_t        e;
        cond = c; aluOp = op; setFlags = s; rdIndex = rd; rnData = a; operand2 = b;
        shifterCarry = shc; inValid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (inReady) begin
                pass = cond_ok(c, m_flags);
                test = (op >= 4'h8) && (op <= 4'hB);
                model_op(op, a, b, shc, m_flags, r, nf);
                e.res = r; e.rd = rd; e.we = pass && !test;
                sb_q.push_back(e);
                if (pass && (s || test)) m_flags = nf;
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        inValid = 1'b0;
        check("flags", {28'd0, flags}, {28'd0, m_flags});
    endtask

    // Output side of the scoreboard: compare on every completed transfer
    always @(negedge clk) begin
        exp_t e;
        if (resetN && outValid && outReady) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("rd", {28'd0, rdOut}, {28'd0, e.rd});
                check("we", {31'd0, writeEn}, {31'd0, e.we});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 outReady = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        resetN = 1'b0; inValid = 1'b1; outReady = 1'b1; cond = 4'hE; aluOp = 4'h4;
        setFlags = 1'b1; rdIndex = 4'd3; rnData = 32'd9; operand2 = 32'd9; shifterCarry = 1'b1;
        m_flags = 4'b0000;

        // Reset holds everything even with a valid op presented
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, outValid}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", {28'd0, rdOut}, 32'd0);
        check("rst_we", {31'd0, writeEn}, 32'd0);
        @(posedge clk); #1;
        inValid = 1'b0; resetN = 1'b1;

        issue(4'hE, 4'h4, 1'b0, 4'd1, 32'd5, 32'd7, 1'b0);
        check("add_result", result, 32'd12);
        check("add_we", {31'd0, writeEn}, 32'd1);
        check("add_valid", {31'd0, outValid}, 32'd1);

        issue(4'hE, 4'h2, 1'b1, 4'd2, 32'd3, 32'd3, 1'b0);
        check("subs_flags", {28'd0, flags}, 32'b0110);
        issue(4'hE, 4'h4, 1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
        check("adds_ovf_result", result, 32'h8000_0000);
        check("adds_ovf_flags", {28'd0, flags}, 32'b1001);

        // Conditional chain: CMP 1,2 then LT passes, GE fails
        issue(4'hE, 4'hA, 1'b0, 4'd0, 32'd1, 32'd2, 1'b0);
        check("cmp_flags", {28'd0, flags}, 32'b1000);
        issue(4'hB, 4'hD, 1'b0, 4'd4, 32'd0, 32'd9, 1'b0);
        check("movlt_we", {31'd0, writeEn}, 32'd1);
        check("movlt_result", result, 32'd9);
        issue(4'hA, 4'hD, 1'b1, 4'd5, 32'd0, 32'd4, 1'b1);
        check("movge_we", {31'd0, writeEn}, 32'd0);
        check("movge_result", result, 32'd4);
        check("movge_flags", {28'd0, flags}, 32'b1000);

        // Carry chain
        issue(4'hE, 4'h4, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("adds_carry_flags", {28'd0, flags}, 32'b0110);
        issue(4'hE, 4'h5, 1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
        check("adc_result", result, 32'd1);
        issue(4'hE, 4'hA, 1'b0, 4'd0, 32'd1, 32'd2, 1'b0);
        issue(4'hE, 4'h6, 1'b0, 4'd8, 32'd5, 32'd2, 1'b0);
        check("sbc_result", result, 32'd2);

        // Logical op takes shifter carry and keeps V
        issue(4'hE, 4'h4, 1'b1, 4'd9, 32'h7FFF_FFFF, 32'd1, 1'b0);
        issue(4'hE, 4'h0, 1'b1, 4'd9, 32'hF0, 32'h0F, 1'b1);
        check("ands_flags", {28'd0, flags}, 32'b0111);

        // Backpressure: drain, then stall the first op while a second waits
        repeat (2) @(posedge clk);
        #1 outReady = 1'b0;
        issue(4'hE, 4'h4, 1'b0, 4'd10, 32'd10, 32'd20, 1'b0);
        fork
            issue(4'hE, 4'h2, 1'b0, 4'd11, 32'd50, 32'd8, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_ready", {31'd0, inReady}, 32'd0);
                    check("stall_valid", {31'd0, outValid}, 32'd1);
                    check("stall_result", result, 32'd30);
                    check("stall_rd", {28'd0, rdOut}, 32'd10);
                    check("stall_we", {31'd0, writeEn}, 32'd1);
                end
                @(posedge clk); #1 outReady = 1'b1;
            end
        join
        check("second_result", result, 32'd42);
        check("second_rd", {28'd0, rdOut}, 32'd11);
        issue(4'hE, 4'h8, 1'b0, 4'd12, 32'hFF, 32'h100, 1'b0);
        check("tst_we", {31'd0, writeEn}, 32'd0);

        // Asynchronous reset mid-operation discards held result and flags
        @(posedge clk); #1 outReady = 1'b0;
        issue(4'hE, 4'h4, 1'b1, 4'd13, 32'h7FFF_FFFF, 32'd1, 1'b0);
        #2 resetN = 1'b0;
        #1;
        check("midrst_valid", {31'd0, outValid}, 32'd0);
        check("midrst_flags", {28'd0, flags}, 32'd0);
        check("midrst_result", result, 32'd0);
        sb_q.delete();
        m_flags = 4'b0000;
        @(posedge clk); #1 resetN = 1'b1; outReady = 1'b1;
        issue(4'h0, 4'h4, 1'b1, 4'd14, 32'd1, 32'd1, 1'b0);
        check("post_rst_eq_we", {31'd0, writeEn}, 32'd0);

        // Random traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), rand_val(), rand_val(), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2 outReady = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_execute.md
Name: alu_execute

Overview:
- Registered execute stage directly downstream of the operand-2 shifter.
- Consumes Rn data plus the shifted operand 2, evaluates the ARM condition field against the current NZCV flags, and performs all 16 data-processing ops.
- Updates the flag register when the S bit is set, and presents a registered result to writeback over a valid/ready handshake.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 4, destination register index width.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- inValid  in  1  upstream operation valid.
- inReady  out  1  stage can accept an operation this cycle.
- cond  in  4  ARM condition field.
- aluOp  in  4  data-processing opcode, bits 24:21.
- setFlags  in  1  S bit.
- rdIndex  in  REG_W  destination register.
- rnData  in  DATA_W  first operand.
- operand2  in  DATA_W  shifter output.
- shifterCarry  in  1  shifter carry-out, used by logical ops.
- outValid  out  1  result register valid.
- outReady  in  1  downstream accepts the result.
- result  out  DATA_W  registered ALU result.
- rdOut  out  REG_W  registered destination.
- writeEn  out  1  result must be written to rdOut.
- flags  out  4  current {N,Z,C,V}.

Behaviour:
- Reset, asynchronous on resetN low: outValid=0, result=0, rdOut=0, writeEn=0, flags=4'b0000.
- Reset mid-operation discards the held result; no partial flag update survives.
- Handshake:
  - inReady = !outValid || outReady (combinational).
  - A transfer occurs when inValid && inReady.
  - Latency is 1 cycle: an op accepted at edge k appears with outValid=1 after edge k.
  - While outValid && !outReady, result, rdOut, writeEn and outValid hold stable and no input is accepted.
  - If outValid && outReady && !inValid, outValid clears at the next edge.
- Condition evaluation uses the flags register value at the accepting edge:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 4'b1111 is treated as never.
- Failed condition: the op still transfers (outValid=1), writeEn=0, result=computed value, flags unchanged.
- Ops and results:
  - AND 0 Rn&Op2; EOR 1 Rn^Op2; SUB 2 Rn-Op2; RSB 3 Op2-Rn.
  - ADD 4 Rn+Op2; ADC 5 Rn+Op2+C; SBC 6 Rn-Op2-!C; RSC 7 Op2-Rn-!C.
  - TST 8 AND; TEQ 9 EOR; CMP A SUB; CMN B ADD.
  - ORR C Rn|Op2; MOV D Op2; BIC E Rn&~Op2; MVN F ~Op2.
- writeEn = condPass && aluOp not in 8..B.
- Arithmetic:
  - Computed as a 33-bit add; subtraction is A + ~B + carryIn, with carryIn=1 for SUB/RSB/CMP and carryIn=C for SBC/RSC.
  - C = bit 32, so subtract carry = NOT borrow.
  - V = (A[31]==B'[31]) && (R[31]!=A[31]), where B' is the inverted operand for subtracts.
- Flag update happens at the accepting edge when condPass && (setFlags || aluOp in 8..B):
  - N = R[31], Z = (R==0).
  - Arithmetic ops update C and V.
  - Logical ops set C = shifterCarry and leave V unchanged.
- Back-to-back ops: the op accepted at edge k+1 sees flags written at edge k. No bubble and no forwarding hazard.
- Flags update at the accepting edge even if the result is later held by backpressure.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_AND..OP_MVN;
  - condition constants COND_EQ..COND_NV;
  - flag bit indices FLAG_N/Z/C/V.
- One combinational sub-module, cond_check (cond, flags -> pass), instantiated once.
- The ALU core and pipeline/flag registers live in alu_execute.

Test Plan:
- Reset: hold resetN=0, drive inValid=1 -> outValid=0, flags=0000, result=0; release, ADD Rn=5 Op2=7 cond=AL -> result=12 one cycle later, writeEn=1.
- Flags: SUBS Rn=3 Op2=3 -> result=0, flags N0 Z1 C1 V0. Next ADDS Rn=32'h7FFFFFFF Op2=1 -> result=32'h80000000, N1 Z0 C0 V1.
- Conditional chain: CMP Rn=1 Op2=2 (N=1, C=0), then back-to-back MOVLT Op2=9, then MOVGE Op2=4 -> first writeEn=1 result=9; second writeEn=0, flags unchanged.
- Carry chain: ADDS 32'hFFFFFFFF+1 (C=1), then ADC Rn=0 Op2=0 -> result=1. SBC Rn=5 Op2=2 with C=0 -> result=2.
- Logical carry: ANDS Rn=32'hF0 Op2=32'h0F, shifterCarry=1, prior V=1 -> Z=1, C=1, V stays 1.
- Backpressure: outReady=0 for 3 cycles with a second op pending -> inReady=0, outputs stable. Raise outReady -> second op appears the next cycle; TST issued meanwhile produces writeEn=0.
